money_scan_display: RTL and testbench
=====================================

// Module: money_scan_display
//
// PURPOSE
//  Display formatter for the ticket vending machine. Converts the binary
//  paid amount, selected ticket type, ticket count and change amount into
//  eight 4-bit BCD digits for the 8-digit 7-segment scanner.
//  Sits between the vending controller (source of money/ticket/change)
//  and the segment multiplexer/decoder (consumer of d7..d0).
//
// PARAMETERS
//  None. Digit width is fixed at 4 bits. Binary inputs are fixed at 8 bits.
//
// PORTS
//  clke         in   1  system clock, rising edge
//  rst          in   1  asynchronous reset, active-high
//  money        in   8  amount inserted, binary 0..255
//  ticketType   in   3  ticket type code; 0..3 valid
//  ticketCount  in   3  number of tickets, 0..7
//  moneyReturn  in   8  change to return, binary 0..255
//  d7..d0       out  4  each: BCD digit or code for display position 7..0
//
// BEHAVIOUR
//  - One clock (clke); reset is asynchronous and active-high (rst).
//  - While rst=1: all of d7..d0 = 4'h0, independent of clke.
//  - Digit map, updated on every rising clke edge when rst=0:
//      d7 d6 d5 = hundreds, tens, units of money (BCD)
//      d4       = ticketType if 0..3; 4'hE (error) if 4..7
//      d3       = ticketCount (0..7, passed through zero-extended)
//      d2 d1 d0 = hundreds, tens, units of moneyReturn (BCD)
//  - Latency: outputs are registered. An input change appears on d7..d0
//    exactly 1 clke edge later. There is no enable and no handshake.
//  - Conversion is combinational (double-dabble) ahead of the output
//    registers. Full 8-bit range is supported, e.g. 255 -> 2,5,5.
//    Hundreds digit is 0..2.
//  - No leading-zero blanking: 20 shows as 0,2,0 and 0 shows as 0,0,0.
//  - Each input path is independent. Simultaneous changes on all inputs
//    land together on the same edge.
//  - Reset asserted mid-operation clears the outputs immediately.
//    On the first clke edge after rst deasserts, the outputs reflect the
//    current inputs.
//  - All BCD digits are always in 0..9. The only non-BCD code produced
//    is 4'hE on d4.
//
// STRUCTURE
//  - Shared package: DIGIT_ERR = 4'hE and MAX_TICKET_TYPE = 3, used by the
//    controller and the segment decoder.
//  - One sub-module, bin8_to_bcd3: input bin[7:0], outputs
//    hund[3:0]/tens[3:0]/ones[3:0], purely combinational shift-add-3.
//    Instantiated twice: once for money, once for moneyReturn.
//  - The top level contains only the type check, the count
//    pass-through and the 32 output flops.
//
// TESTING
//  1 rst=1, any inputs -> d7..d0 all 0 without a clke edge.
//    Release rst -> outputs update on the next edge.
//  2 money=120, type=0, count=3, return=20, one edge ->
//    d7..d0 = 1,2,0, 0, 3, 0,2,0.
//  3 Hold case 2, step ticketType 1 -> 2 -> 3, 30 ns each ->
//    d4 follows 1, 2, 3 one edge later; all other digits unchanged.
//  4 ticketType=5 -> d4=4'hE. ticketType=7 -> d4=4'hE.
//  5 money=255, return=0 -> 2,5,5 / 0,0,0. money=9, return=199 ->
//    0,0,9 / 1,9,9. Sweep all 256 values on both inputs against a
//    reference divide/modulo model.
//  6 Assert rst between two edges with non-zero outputs ->
//    all digits drop to 0 asynchronously and stay 0 while rst=1.

Source files
------------

// File: rtl/money_scan_display_pkg.sv
// Shared display constants and BCD helpers for the ticket machine front panel.
// Used by the formatter, the vending controller and the segment decoder.
package money_scan_display_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t     DIGIT_ERR       = 4'hE;
    localparam logic [2:0] MAX_TICKET_TYPE = 3'd3;

    // Double-dabble correction step: a BCD column of 5 or more overflows
    // past 9 on the next left shift, so it is pre-biased by 3.
    function automatic digit_t add3(input digit_t n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/money_scan_display_bin8_to_bcd3.sv
// Purpose: 8-bit binary to three BCD digits (hundreds 0..2, tens, ones).
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows input continuously.
module bin8_to_bcd3 (
    input  logic [7:0] bin,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    import money_scan_display_pkg::*;

    logic [19:0] shift;

    always_comb begin
        shift = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            shift[11:8]  = add3(shift[11:8]);
            shift[15:12] = add3(shift[15:12]);
            shift[19:16] = add3(shift[19:16]);
            shift        = shift << 1;
        end
    end

    assign hund = shift[19:16];
    assign tens = shift[15:12];
    assign ones = shift[11:8];

endmodule

// File: rtl/money_scan_display.sv
// Purpose: format money, ticket type/count and change into 8 display digits.
// Latency: one clke edge from any input change to d7..d0.
// Backpressure: none, no enable or handshake; outputs reload every edge.
module money_scan_display (
    input  logic       clke,
    input  logic       rst,
    input  logic [7:0] money,
    input  logic [2:0] ticketType,
    input  logic [2:0] ticketCount,
    input  logic [7:0] moneyReturn,
    output logic [3:0] d7,
    output logic [3:0] d6,
    output logic [3:0] d5,
    output logic [3:0] d4,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);
    import money_scan_display_pkg::*;

    logic [3:0] money_h, money_t, money_o;
    logic [3:0] ret_h, ret_t, ret_o;
    logic [3:0] type_digit;

    bin8_to_bcd3 u_money_bcd (
        .bin  (money),
        .hund (money_h),
        .tens (money_t),
        .ones (money_o)
    );

    bin8_to_bcd3 u_return_bcd (
        .bin  (moneyReturn),
        .hund (ret_h),
        .tens (ret_t),
        .ones (ret_o)
    );

    // Codes 4..7 are not sold; show the error glyph rather than a bogus digit.
    assign type_digit = (ticketType <= MAX_TICKET_TYPE) ? {1'b0, ticketType} : DIGIT_ERR;

    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            d7 <= 4'h0;
            d6 <= 4'h0;
            d5 <= 4'h0;
            d4 <= 4'h0;
            d3 <= 4'h0;
            d2 <= 4'h0;
            d1 <= 4'h0;
            d0 <= 4'h0;
        end else begin
            d7 <= money_h;
            d6 <= money_t;
            d5 <= money_o;
            d4 <= type_digit;
            d3 <= {1'b0, ticketCount};
            d2 <= ret_h;
            d1 <= ret_t;
            d0 <= ret_o;
        end
    end

endmodule

// File: tb/tb_money_scan_display.sv
// Scoreboarded bench: stimulus pushes expected digit words, a monitor pops
// and compares one edge later; reset behaviour is checked directly.
module tb_money_scan_display;

    logic       clke = 1'b0;
    logic       rst;
    logic [7:0] money;
    logic [2:0] ticketType;
    logic [2:0] ticketCount;
    logic [7:0] moneyReturn;
    logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];

    money_scan_display dut (
        .clke        (clke),
        .rst         (rst),
        .money       (money),
        .ticketType  (ticketType),
        .ticketCount (ticketCount),
        .moneyReturn (moneyReturn),
        .d7 (d7), .d6 (d6), .d5 (d5), .d4 (d4),
        .d3 (d3), .d2 (d2), .d1 (d1), .d0 (d0)
    );

    always #5 clke = ~clke;

    function automatic logic [31:0] digits();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    // Reference: decimal digits by divide/modulo, type > 3 shows 'E'.
    function automatic logic [31:0] model(input int m, input int t, input int c, input int r);
        logic [3:0] tt;
        tt = (t > 3) ? 4'hE : 4'(t);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10), tt, 4'(c),
                4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic apply(input int m, input int t, input int c, input int r);
        @(negedge clke);
        money       = 8'(m);
        ticketType  = 3'(t);
        ticketCount = 3'(c);
        moneyReturn = 8'(r);
        expq.push_back(model(m, t, c, r));
    endtask

    task automatic release_rst();
        @(negedge clke);
        rst = 1'b0;
        expq.push_back(model(int'(money), int'(ticketType), int'(ticketCount), int'(moneyReturn)));
    endtask

    // Monitor: every edge out of reset presents one output word.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clke);
            #1;
            if (!rst && expq.size() > 0) begin
                e = expq.pop_front();
                check("digits", digits(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        money       = 8'd187;
        ticketType  = 3'd6;
        ticketCount = 3'd5;
        moneyReturn = 8'd99;
        #1;
        check("reset_no_edge", digits(), 32'h0);
        repeat (2) @(posedge clke);
        #1;
        check("reset_held", digits(), 32'h0);
        release_rst();

        apply(120, 0, 3, 20);
        for (int t = 1; t <= 3; t++)
            repeat (3) apply(120, t, 3, 20);
        apply(120, 5, 3, 20);
        apply(120, 7, 3, 20);
        apply(255, 1, 7, 0);
        apply(9, 2, 0, 199);
        apply(0, 4, 1, 0);

        for (int i = 0; i < 256; i++)
            apply(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 255 - i);
        for (int i = 0; i < 200; i++)
            apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));

        apply(120, 2, 3, 20);
        @(posedge clke);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", digits(), 32'h0);
        repeat (2) begin
            @(posedge clke);
            #1;
            check("reset_hold_edges", digits(), 32'h0);
        end
        release_rst();
        apply(201, 3, 6, 108);

        repeat (2) @(posedge clke);
        #2;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
